// File: rtl/act_requant_stage_pkg.sv
// rtl/act_requant_stage_pkg.sv - Q8.8 format constants and beat type shared by the requant and activation stages
package act_requant_stage_pkg;

  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 8;

  localparam logic [OUT_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] SAT_MIN = 16'h8000;

  typedef struct packed {
    logic             valid;
    logic [OUT_W-1:0] data;
  } q88_beat_t;

  function automatic logic [OUT_W-1:0] sat_code(input logic negative);
    return negative ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/act_round_sat.sv
// rtl/act_round_sat.sv - combinational round-half-up, arithmetic shift and saturate to Q8.8
// Also used at the other requant points in the datapath.
module act_round_sat
  import act_requant_stage_pkg::*;
#(
  parameter int IN_W = 33,
  parameter int SH   = 8
) (
  input  logic signed [IN_W-1:0]  sum,
  output logic        [OUT_W-1:0] data,
  output logic                    sat
);

  // One guard bit so adding the rounding half can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] HALF  = RW'(2 ** (SH - 1));
  localparam logic signed [RW-1:0] R_MAX = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] r;
  logic                 over;
  logic                 under;

  always_comb begin
    biased = {sum[IN_W-1], sum} + HALF;
    r      = biased >>> SH;
    over   = r > R_MAX;
    under  = r < R_MIN;
    sat    = over | under;
    data   = sat ? sat_code(under) : r[OUT_W-1:0];
  end

endmodule

// File: rtl/act_requant_stage.sv
// rtl/act_requant_stage.sv - two-stage bias/round/saturate requantiser feeding siluPWL.x
// Optional saturation counter and sat_cnt port enabled by `ACT_SATCNT_EN.
module act_requant_stage
  import act_requant_stage_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int ACC_FRAC = 16,
  parameter int CH_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_addr,
  input  logic [ACC_W-1:0] cfg_bias,
  input  logic             cfg_nch_we,
  input  logic [CH_W-1:0]  cfg_nch
`ifdef ACT_SATCNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int SH    = ACC_FRAC - OUT_FRAC;
  localparam int DEPTH = 2 ** CH_W;
  localparam int SUM_W = ACC_W + 1;

  logic [ACC_W-1:0]        bias_tbl [DEPTH];
  logic [CH_W-1:0]         nch;
  logic [CH_W-1:0]         ch;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [SUM_W-1:0] sum_d;
  q88_beat_t               s2_q;
  logic                    s2_adv;
  logic                    accept;
  logic [OUT_W-1:0]        rs_data;
  logic                    rs_sat;

  assign s2_adv    = !s2_q.valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_q.valid;
  assign out_data  = s2_q.data;

  assign sum_d = $signed({in_data[ACC_W-1], in_data})
               + $signed({bias_tbl[ch][ACC_W-1], bias_tbl[ch]});

  // A write landing on the index being read this cycle only becomes visible next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bias_tbl[i] <= '0;
    end else if (cfg_we) begin
      bias_tbl[cfg_addr] <= cfg_bias;
    end
  end

  // >= rather than == so a channel left above a freshly lowered nch still wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nch <= '1;
      ch  <= '0;
    end else begin
      if (cfg_nch_we) nch <= cfg_nch;
      if (accept)     ch  <= (in_last || ch >= nch) ? '0 : ch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sum   <= sum_d;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  act_round_sat #(
    .IN_W (SUM_W),
    .SH   (SH)
  ) u_round_sat (
    .sum  (s1_sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else if (s2_adv) begin
      s2_q.valid <= s1_valid;
      if (s1_valid) s2_q.data <= rs_data;
    end
  end

`ifdef ACT_SATCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (s2_adv && s1_valid && rs_sat && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic sat_unused;
  assign sat_unused = rs_sat;
`endif

endmodule
